// File: rtl/punc_mem_responder_pkg.sv
// Shared types and constants for the PUnC memory responder.
package punc_mem_responder_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 16;

    localparam logic [15:0] OOR_RDATA = 16'h0000;

endpackage

// File: rtl/punc_mem_responder_store.sv
// Word store: synchronous write, registered FSM read, combinational debug read.
module punc_word_store
    import punc_mem_responder_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o    = rdata_q;
    assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/punc_mem_responder.sv
// Memory-side responder: one request at a time, programmable wait states,
// response held until consumed.
module punc_mem_responder
    import punc_mem_responder_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [15:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    input  logic [15:0]       mem_debug_addr,
    output logic [DATA_W-1:0] mem_debug_data
);

    localparam logic [3:0] CNT_INIT =
        (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [15:0]       addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;

    logic              mem_we, mem_re, in_range, dbg_in_range;
    logic [DATA_W-1:0] store_rdata, store_dbg;

    assign in_range     = (addr_q[15:ADDR_W] == '0);
    assign dbg_in_range = (mem_debug_addr[15:ADDR_W] == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        mem_re  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                mem_we  = we_q & in_range;
                mem_re  = ~we_q & in_range;
                err_d   = ~in_range;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    punc_word_store #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_store (
        .clk       (clk),
        .we_i      (mem_we),
        .waddr_i   (addr_q[ADDR_W-1:0]),
        .wdata_i   (wdata_q),
        .re_i      (mem_re),
        .raddr_i   (addr_q[ADDR_W-1:0]),
        .rdata_o   (store_rdata),
        .dbg_addr_i(mem_debug_addr[ADDR_W-1:0]),
        .dbg_data_o(store_dbg)
    );

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_err   = err_q;
    // The store's read register only counts while a read response is live.
    assign resp_rdata = (resp_valid && !we_q && !err_q)
                      ? store_rdata : DATA_W'(OOR_RDATA);
    assign mem_debug_data = dbg_in_range ? store_dbg : DATA_W'(OOR_RDATA);

endmodule

// File: tb/tb_punc_mem_responder.sv
// Directed bench: one responder with 2 wait states, one with none.
module tb_punc_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        a_valid = 0, a_we = 0, a_rready = 0;
    logic [15:0] a_addr = 0, a_wdata = 0, a_dbg = 0;
    logic        a_req_ready, a_resp_valid, a_resp_err;
    logic [15:0] a_rdata, a_dbg_data;

    logic        b_valid = 0, b_we = 0, b_rready = 0;
    logic [15:0] b_addr = 0, b_wdata = 0, b_dbg = 0;
    logic        b_req_ready, b_resp_valid, b_resp_err;
    logic [15:0] b_rdata, b_dbg_data;

    int errors = 0;
    int checks = 0;

    punc_mem_responder #(.WAIT_STATES(2)) u_ws2 (
        .clk(clk), .rst(rst),
        .req_valid(a_valid), .req_ready(a_req_ready),
        .req_we(a_we), .req_addr(a_addr), .req_wdata(a_wdata),
        .resp_valid(a_resp_valid), .resp_ready(a_rready),
        .resp_rdata(a_rdata), .resp_err(a_resp_err),
        .mem_debug_addr(a_dbg), .mem_debug_data(a_dbg_data)
    );

    punc_mem_responder #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst),
        .req_valid(b_valid), .req_ready(b_req_ready),
        .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata),
        .resp_valid(b_resp_valid), .resp_ready(b_rready),
        .resp_rdata(b_rdata), .resp_err(b_resp_err),
        .mem_debug_addr(b_dbg), .mem_debug_data(b_dbg_data)
    );

    // Returns edges from acceptance to first resp_valid (20 = timeout).
    task automatic req_a(input logic we, input logic [15:0] addr,
                         input logic [15:0] wd, input logic rr,
                         output int lat, output logic [15:0] rd,
                         output logic err);
        @(negedge clk);
        a_we = we; a_addr = addr; a_wdata = wd;
        a_valid = 1'b1; a_rready = rr;
        @(negedge clk);
        a_valid = 1'b0;
        lat = 0;
        while (!a_resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = a_rdata; err = a_resp_err;
    endtask

    task automatic req_b(input logic we, input logic [15:0] addr,
                         input logic [15:0] wd,
                         output int lat, output logic [15:0] rd,
                         output logic err);
        @(negedge clk);
        b_we = we; b_addr = addr; b_wdata = wd;
        b_valid = 1'b1; b_rready = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        lat = 0;
        while (!b_resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = b_rdata; err = b_resp_err;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_req_ready, a_resp_valid, a_resp_err} !== 3'b100) begin
            errors++;
            $display("FAIL reset_ctl_a: got rdy/vld/err=%b%b%b want 100",
                     a_req_ready, a_resp_valid, a_resp_err);
        end
        checks++;
        if (a_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rdata_a: got %h want 0000", a_rdata);
        end
        checks++;
        if ({b_req_ready, b_resp_valid, b_resp_err, b_rdata} !==
            {3'b100, 16'h0000}) begin
            errors++;
            $display("FAIL reset_b: got %b%b%b %h want 100 0000",
                     b_req_ready, b_resp_valid, b_resp_err, b_rdata);
        end
    endtask

    task automatic test_write_read();
        int lat; logic [15:0] rd; logic err;
        req_a(1'b1, 16'h0005, 16'hBEEF, 1'b1, lat, rd, err);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL wr_latency: got %0d want 3", lat);
        end
        checks++;
        if ({err, rd} !== {1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL wr_resp: got err=%b rd=%h want 0 0000", err, rd);
        end
        a_dbg = 16'h0005; #1;
        checks++;
        if (a_dbg_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL wr_debug: got %h want beef", a_dbg_data);
        end
        req_a(1'b0, 16'h0005, 16'h0000, 1'b1, lat, rd, err);
        checks++;
        if ({lat, err, rd} !== {32'd3, 1'b0, 16'hBEEF}) begin
            errors++;
            $display("FAIL rd_back: got lat=%0d err=%b rd=%h want 3 0 beef",
                     lat, err, rd);
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [15:0] rd; logic err;
        req_a(1'b1, 16'h0009, 16'h5A5A, 1'b1, lat, rd, err);
        req_a(1'b0, 16'h0009, 16'h0000, 1'b0, lat, rd, err);
        // Offer a stray request while stalled; it must be ignored.
        a_valid = 1'b1; a_we = 1'b1; a_addr = 16'h0009; a_wdata = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({a_resp_valid, a_req_ready, a_rdata} !==
                {2'b10, 16'h5A5A}) begin
                errors++;
                $display("FAIL stall_%0d: got vld=%b rdy=%b rd=%h want 1 0 5a5a",
                         i, a_resp_valid, a_req_ready, a_rdata);
            end
        end
        a_valid = 1'b0; a_rready = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_req_ready, a_resp_valid, a_rdata} !== {2'b10, 16'h0000}) begin
            errors++;
            $display("FAIL release: got rdy=%b vld=%b rd=%h want 1 0 0000",
                     a_req_ready, a_resp_valid, a_rdata);
        end
        a_dbg = 16'h0009; #1;
        checks++;
        if (a_dbg_data !== 16'h5A5A) begin
            errors++;
            $display("FAIL stray_ignored: got %h want 5a5a", a_dbg_data);
        end
    endtask

    task automatic test_out_of_range();
        int lat; logic [15:0] rd; logic err;
        req_a(1'b1, 16'h0000, 16'hC0DE, 1'b1, lat, rd, err);
        req_a(1'b1, 16'h0400, 16'h1234, 1'b1, lat, rd, err);
        checks++;
        if ({err, rd} !== {1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL oor_wr: got err=%b rd=%h want 1 0000", err, rd);
        end
        a_dbg = 16'h0000; #1;
        checks++;
        if (a_dbg_data !== 16'hC0DE) begin
            errors++;
            $display("FAIL oor_alias: got %h want c0de", a_dbg_data);
        end
        a_dbg = 16'h0400; #1;
        checks++;
        if (a_dbg_data !== 16'h0000) begin
            errors++;
            $display("FAIL oor_debug: got %h want 0000", a_dbg_data);
        end
        req_a(1'b0, 16'hFFFF, 16'h0000, 1'b1, lat, rd, err);
        checks++;
        if ({err, rd} !== {1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL oor_rd: got err=%b rd=%h want 1 0000", err, rd);
        end
        @(negedge clk);
        checks++;
        if ({a_resp_err, a_req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL oor_clear: got err=%b rdy=%b want 0 1",
                     a_resp_err, a_req_ready);
        end
    endtask

    task automatic test_zero_wait();
        int lat; logic [15:0] rd; logic err;
        int acc[$];
        req_b(1'b1, 16'h0003, 16'h7777, lat, rd, err);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL zw_wr_latency: got %0d want 1", lat);
        end
        req_b(1'b0, 16'h0003, 16'h0000, lat, rd, err);
        checks++;
        if ({lat, err, rd} !== {32'd1, 1'b0, 16'h7777}) begin
            errors++;
            $display("FAIL zw_rd: got lat=%0d err=%b rd=%h want 1 0 7777",
                     lat, err, rd);
        end
        @(negedge clk);
        b_valid = 1'b1; b_we = 1'b0; b_addr = 16'h0003;
        for (int i = 0; i < 12; i++) begin
            if (b_req_ready) acc.push_back(i);
            @(negedge clk);
        end
        b_valid = 1'b0;
        checks++;
        if (acc.size() !== 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 4", acc.size());
        end else begin
            for (int k = 1; k < 4; k++) begin
                checks++;
                if (acc[k] - acc[k-1] !== 3) begin
                    errors++;
                    $display("FAIL b2b_gap_%0d: got %0d want 3",
                             k, acc[k] - acc[k-1]);
                end
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat; logic [15:0] rd; logic err;
        req_a(1'b1, 16'h0007, 16'h1111, 1'b1, lat, rd, err);
        @(negedge clk);
        a_we = 1'b1; a_addr = 16'h0007; a_wdata = 16'hAAAA; a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        checks++;
        if (a_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_in_wait: got rdy=%b want 0", a_req_ready);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({a_req_ready, a_resp_valid} !== 2'b10) begin
            errors++;
            $display("FAIL mid_async: got rdy=%b vld=%b want 1 0",
                     a_req_ready, a_resp_valid);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        a_dbg = 16'h0007; #1;
        checks++;
        if (a_dbg_data !== 16'h1111) begin
            errors++;
            $display("FAIL mid_dropped: got %h want 1111", a_dbg_data);
        end
        checks++;
        if (a_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_resp: got vld=%b want 0", a_resp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_backpressure();
        test_out_of_range();
        test_zero_wait();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/punc_mem_responder.md
Name: punc_mem_responder

Overview:
- Memory-side responder for the PUnC LC3 datapath: the target end of the datapath's memory read/write interface.
- Accepts one request at a time on a valid/ready handshake and applies programmable wait states.
- Performs the access on a 1024 x 16 word store and returns read data on a valid/ready response channel.
- Also provides a combinational debug read port for the testbench/top level.

Parameters:
- ADDR_W, 10, index width of the word store (depth = 2**ADDR_W).
- DATA_W, 16, word width.
- WAIT_STATES, 2, extra cycles between request acceptance and the access cycle (legal range 0..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  16  word address from the datapath.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  response present.
- resp_ready  in  1  datapath consumes the response.
- resp_rdata  out  DATA_W  read data (0 for writes and for errors).
- resp_err  out  1  address was out of range.
- mem_debug_addr  in  16  debug read address.
- mem_debug_data  out  DATA_W  debug read data, combinational.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0. Word store contents are not cleared.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1 at a rising edge, latch we, addr and wdata.
  - Next state is WAIT with counter=WAIT_STATES-1, or ACCESS if WAIT_STATES=0.
- WAIT:
  - req_ready=0.
  - The counter decrements each cycle; go to ACCESS when counter=0.
  - Requests are ignored; latched fields are held.
- ACCESS (one cycle):
  - In range means latched addr[15:ADDR_W]==0.
  - In-range write: the word is committed at the edge that leaves ACCESS.
  - In-range read: the word is registered into resp_rdata at that edge.
  - Out of range: no write, resp_rdata=0, resp_err=1.
  - Next state is RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable until resp_ready=1 at an edge, then go to IDLE.
  - At that edge resp_valid, resp_rdata and resp_err clear to 0.
- Latency:
  - Request accepted at edge E0; resp_valid is first high after edge E0+WAIT_STATES+1.
  - The write is visible on the debug port after the same edge.
  - WAIT_STATES=2 gives 3 cycles.
- Throughput: at most one request per WAIT_STATES+3 cycles when resp_ready is held high. There is no acceptance in the same cycle the response completes.
- Read of a just-written word returns the new data (the previous write is complete before the next request is accepted).
- Debug port:
  - mem_debug_data = store[mem_debug_addr[ADDR_W-1:0]] if mem_debug_addr[15:ADDR_W]==0, else 0.
  - It is combinational and independent of the FSM.
- Reset mid-operation: asynchronous return to IDLE. A write still in WAIT or ACCESS before its commit edge is dropped; a pending response is discarded.
- req_* inputs changing while not in IDLE have no effect.

Decomposition:
- Shared package: FSM state encoding (2-bit IDLE/WAIT/ACCESS/RESP), default DATA_W/ADDR_W constants, and the out-of-range read value (16'h0000).
- One natural sub-module, punc_word_store:
  - Synchronous write port (we, waddr, wdata).
  - One registered read port for the FSM.
  - One combinational read port for debug.
  - No reset on the array.
- The FSM, wait counter and response registers live in punc_mem_responder.

Test Plan:
- Reset then idle: hold rst=0 for 3 cycles, release -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- Write then read (WAIT_STATES=2):
  - Write addr 16'h0005 data 16'hBEEF, resp_ready=1 -> resp_valid high exactly 3 edges after acceptance, resp_rdata=0, resp_err=0, mem_debug_addr=5 shows 16'hBEEF.
  - Then read addr 5 -> resp_rdata=16'hBEEF.
- Backpressure: read with resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stay stable, req_ready=0 throughout. Raise resp_ready -> IDLE next cycle, req_ready=1.
- Out-of-range:
  - Write addr 16'h0400 data 16'h1234 -> resp_err=1, resp_rdata=0.
  - Debug read of addr 16'h0000 is unchanged; debug read of 16'h0400 returns 0.
- Zero wait states (WAIT_STATES=0): read accepted at E0 -> resp_valid high after E1. Back-to-back requests accepted every 3 cycles with resp_ready=1.
- Reset mid-operation: write addr 7 data 16'hAAAA, assert rst during WAIT -> IDLE immediately, resp_valid=0, debug addr 7 keeps its prior value.
